// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition-code encodings and NZCV flag bit positions.
package cpu_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of an instruction condition field against NZCV flags.
module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v;

    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];

    // Decode the condition field; the reserved encoding never executes.
    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = ~z & (n == v);
            COND_LE: CondEx = z | (n != v);
            COND_AL: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution unit: owns the NZCV register, gates decoder write/branch
// requests by the condition result, and counts executed and squashed instructions.
module cond_logic
    import cpu_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             InstrValid,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SquashCount
);

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] exec_q, exec_d;
    logic [CNT_W-1:0] squash_q, squash_d;
    logic             cond_ex;

    // Condition is judged on registered flags only, so ALUFlags never reaches an output.
    cond_check u_cond_check (
        .Cond   (Cond),
        .Flags  (flags_q),
        .CondEx (cond_ex)
    );

    assign CondEx      = cond_ex;
    assign PCSrc       = PCS  & cond_ex & InstrValid;
    assign RegWrite    = RegW & cond_ex & InstrValid;
    assign MemWrite    = MemW & cond_ex & InstrValid;
    assign Flags       = flags_q;
    assign ExecCount   = exec_q;
    assign SquashCount = squash_q;

    // Next-state: partial flag loads and counter bumps for valid instructions.
    always_comb begin
        flags_d  = flags_q;
        exec_d   = exec_q;
        squash_d = squash_q;
        if (InstrValid) begin
            if (cond_ex) begin
                if (FlagW[1]) begin
                    flags_d[FLAG_N] = ALUFlags[FLAG_N];
                    flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
                end
                if (FlagW[0]) begin
                    flags_d[FLAG_C] = ALUFlags[FLAG_C];
                    flags_d[FLAG_V] = ALUFlags[FLAG_V];
                end
                exec_d = exec_q + CntOne;
            end else begin
                squash_d = squash_q + CntOne;
            end
        end
    end

    // State registers; reset wins over any same-cycle update.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q  <= 4'b0000;
            exec_q   <= '0;
            squash_q <= '0;
        end else begin
            flags_q  <= flags_d;
            exec_q   <= exec_d;
            squash_q <= squash_d;
        end
    end

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: directed vector table, full condition sweep,
// counter wrap / reset priority sequence, and randomized traffic against a model.
module tb_cond_logic;

    localparam int unsigned CNT_W = 4;
    localparam int          CNT_MOD = 1 << CNT_W;

    logic             clk;
    logic             reset;
    logic             InstrValid;
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS, RegW, MemW;
    logic             PCSrc, RegWrite, MemWrite, CondEx;
    logic [3:0]       Flags;
    logic [CNT_W-1:0] ExecCount, SquashCount;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    logic [3:0] m_flags;
    int         m_exec;
    int         m_squash;

    typedef struct {
        logic       valid;
        logic [3:0] cond;
        logic [3:0] alu;
        logic [1:0] fw;
        logic       pcs, regw, memw;
        logic       ce, pcsrc, regwrite, memwrite;
        logic [3:0] flags;
        int         exec;
        int         squash;
    } vec_t;

    vec_t vecs [9];

    cond_logic #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .InstrValid  (InstrValid),
        .Cond        (Cond),
        .ALUFlags    (ALUFlags),
        .FlagW       (FlagW),
        .PCS         (PCS),
        .RegW        (RegW),
        .MemW        (MemW),
        .PCSrc       (PCSrc),
        .RegWrite    (RegWrite),
        .MemWrite    (MemWrite),
        .CondEx      (CondEx),
        .Flags       (Flags),
        .ExecCount   (ExecCount),
        .SquashCount (SquashCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Condition semantics: pairs of codes share a predicate, odd code is its negation.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        if (c == 4'hF) return 1'b0;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    function automatic void model_tick(input logic rst, input logic v, input logic ce,
                                       input logic [3:0] a, input logic [1:0] fw);
        if (rst) begin
            m_flags = 4'b0000; m_exec = 0; m_squash = 0;
        end else if (v) begin
            if (ce) begin
                if (fw[1]) m_flags[3:2] = a[3:2];
                if (fw[0]) m_flags[1:0] = a[1:0];
                m_exec = (m_exec + 1) % CNT_MOD;
            end else begin
                m_squash = (m_squash + 1) % CNT_MOD;
            end
        end
    endfunction

    task automatic drive(input logic rst, input logic v, input logic [3:0] c,
                         input logic [3:0] a, input logic [1:0] fw,
                         input logic p, input logic r, input logic m);
        reset = rst; InstrValid = v; Cond = c; ALUFlags = a; FlagW = fw;
        PCS = p; RegW = r; MemW = m;
    endtask

    // One instruction cycle checked against the model, before and after the edge.
    task automatic step(input logic rst, input logic v, input logic [3:0] c,
                        input logic [3:0] a, input logic [1:0] fw,
                        input logic p, input logic r, input logic m);
        logic ce;
        @(negedge clk);
        drive(rst, v, c, a, fw, p, r, m);
        #1;
        ce = ref_cond(c, m_flags);
        chk("CondEx", 32'(CondEx), 32'(ce));
        chk("PCSrc", 32'(PCSrc), 32'(p & ce & v));
        chk("RegWrite", 32'(RegWrite), 32'(r & ce & v));
        chk("MemWrite", 32'(MemWrite), 32'(m & ce & v));
        @(posedge clk);
        model_tick(rst, v, ce, a, fw);
        #1;
        chk("Flags", 32'(Flags), 32'(m_flags));
        chk("ExecCount", 32'(ExecCount), 32'(m_exec));
        chk("SquashCount", 32'(SquashCount), 32'(m_squash));
    endtask

    initial begin
        vecs[0] = '{1'b1, 4'h0, 4'h0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 0, 1};
        vecs[1] = '{1'b1, 4'hE, 4'h6, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h6, 1, 1};
        vecs[2] = '{1'b1, 4'h0, 4'hF, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h6, 2, 1};
        vecs[3] = '{1'b1, 4'hE, 4'h9, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hA, 3, 1};
        vecs[4] = '{1'b1, 4'hE, 4'h4, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4, 4, 1};
        vecs[5] = '{1'b1, 4'h1, 4'h0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h4, 4, 2};
        vecs[6] = '{1'b0, 4'hE, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4, 4, 2};
        vecs[7] = '{1'b1, 4'h0, 4'h3, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h7, 5, 2};
        vecs[8] = '{1'b1, 4'hF, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h7, 5, 3};

        // Reset
        drive(1'b1, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        m_flags = 4'b0000; m_exec = 0; m_squash = 0;
        chk("reset Flags", 32'(Flags), 32'h0);
        chk("reset ExecCount", 32'(ExecCount), 32'h0);
        chk("reset SquashCount", 32'(SquashCount), 32'h0);

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(1'b0, vecs[i].valid, vecs[i].cond, vecs[i].alu, vecs[i].fw,
                  vecs[i].pcs, vecs[i].regw, vecs[i].memw);
            #1;
            chk($sformatf("vec%0d CondEx", i), 32'(CondEx), 32'(vecs[i].ce));
            chk($sformatf("vec%0d PCSrc", i), 32'(PCSrc), 32'(vecs[i].pcsrc));
            chk($sformatf("vec%0d RegWrite", i), 32'(RegWrite), 32'(vecs[i].regwrite));
            chk($sformatf("vec%0d MemWrite", i), 32'(MemWrite), 32'(vecs[i].memwrite));
            @(posedge clk);
            model_tick(1'b0, vecs[i].valid, vecs[i].ce, vecs[i].alu, vecs[i].fw);
            #1;
            chk($sformatf("vec%0d Flags", i), 32'(Flags), 32'(vecs[i].flags));
            chk($sformatf("vec%0d ExecCount", i), 32'(ExecCount), 32'(vecs[i].exec));
            chk($sformatf("vec%0d SquashCount", i), 32'(SquashCount), 32'(vecs[i].squash));
        end

        // Sweep every condition code against every flag value
        for (int f = 0; f < 16; f++) begin
            step(1'b0, 1'b1, 4'hE, 4'(f), 2'b11, 1'b0, 1'b0, 1'b0);
            for (int c = 0; c < 16; c++)
                step(1'b0, 1'b0, 4'(c), 4'(15 - f), 2'b11, 1'b1, 1'b1, 1'b1);
        end

        // Counter wrap, then reset beating a same-cycle flag write
        step(1'b1, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++)
            step(1'b0, 1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0);
        chk("wrap pre ExecCount", 32'(ExecCount), 32'd15);
        step(1'b0, 1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0);
        chk("wrap ExecCount", 32'(ExecCount), 32'd0);
        step(1'b0, 1'b1, 4'h1, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'hE, 4'hF, 2'b11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'hE, 4'h7, 2'b11, 1'b1, 1'b1, 1'b1);
        chk("rst-prio Flags", 32'(Flags), 32'h0);
        chk("rst-prio ExecCount", 32'(ExecCount), 32'h0);
        chk("rst-prio SquashCount", 32'(SquashCount), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
                 4'($urandom), 4'($urandom), 2'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
